// File: rtl/ultrasonic_ranger.sv
// HC-SR04-class range-finder controller: trigger generation, echo timing on a
// 1 us tick, centimetre conversion, timeout reporting and a power-of-two
// moving average of valid samples.
`timescale 1ns/1ps
module ultrasonic_ranger #(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned TRIG_US    = 10,
  parameter int unsigned PERIOD_MS  = 60,
  parameter int unsigned TIMEOUT_US = 25000,
  parameter int unsigned US_PER_CM  = 58,
  parameter int unsigned AVG_LOG2   = 2,
  parameter int unsigned DIST_W     = 9,
  parameter int unsigned CONTINUOUS = 1
) (
  input  logic              clk,
  input  logic              reset_p,
  input  logic              echo,
  input  logic              start,
  output logic              trigger,
  output logic [DIST_W-1:0] distance_cm,
  output logic              dist_valid,
  output logic              timeout_err,
  output logic              busy
);

  localparam int unsigned DIV       = CLK_HZ / 1_000_000;
  localparam int unsigned PRE_W     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned US_W      = $clog2(TIMEOUT_US + TRIG_US + 1);
  localparam int unsigned CMD_W     = (US_PER_CM > 1) ? $clog2(US_PER_CM) : 1;
  localparam int unsigned PERIOD_US = PERIOD_MS * 1000;
  localparam int unsigned PER_W     = $clog2(PERIOD_US + TRIG_US + 2 * TIMEOUT_US + 4);
  localparam int unsigned DEPTH     = 1 << AVG_LOG2;
  localparam int unsigned PTR_W     = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int unsigned BUF_N     = 1 << PTR_W;
  localparam int unsigned SUM_W     = DIST_W + AVG_LOG2;

  typedef enum logic [2:0] {
    S_IDLE, S_TRIG, S_WAIT_RISE, S_MEASURE, S_DONE, S_FAIL, S_GAP
  } state_t;

  state_t              r_state, w_next;
  logic                r_arm;
  logic                r_echo_s1, r_echo_s2, r_echo_d;
  logic [PRE_W-1:0]    r_pre;
  logic [US_W-1:0]     r_us_cnt;
  logic [CMD_W-1:0]    r_cm_div;
  logic [DIST_W-1:0]   r_cm_cnt;
  logic [PER_W-1:0]    r_per_cnt;
  logic [DIST_W-1:0]   r_buf [BUF_N];
  logic [PTR_W-1:0]    r_wptr;
  logic                r_empty;
  logic [SUM_W-1:0]    r_sum;
  logic                r_upd;
  logic                r_trigger, r_valid, r_terr;
  logic [DIST_W-1:0]   r_dist;

  logic                w_tick, w_rise, w_fall, w_enter_trig;
  logic [PER_W-1:0]    w_per_next;

  assign w_tick       = (r_pre == PRE_W'(DIV - 1));
  assign w_rise       = r_echo_s2 & ~r_echo_d;
  assign w_fall       = ~r_echo_s2 & r_echo_d;
  assign w_enter_trig = (w_next == S_TRIG) && (r_state != S_TRIG);
  // Period count including the tick of the current cycle, so the next trigger
  // starts exactly PERIOD_US ticks after the previous one.
  assign w_per_next   = r_per_cnt + PER_W'(w_tick);

  assign trigger     = r_trigger;
  assign distance_cm = r_dist;
  assign dist_valid  = r_valid;
  assign timeout_err = r_terr;
  assign busy        = (r_state != S_IDLE);

  // Echo synchroniser, edge-detect copy and start-arming flag
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      r_echo_s1 <= 1'b0;
      r_echo_s2 <= 1'b0;
      r_echo_d  <= 1'b0;
      r_arm     <= 1'b0;
    end else begin
      r_echo_s1 <= echo;
      r_echo_s2 <= r_echo_s1;
      r_echo_d  <= r_echo_s2;
      r_arm     <= 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:      if (r_arm && ((CONTINUOUS != 0) || start)) w_next = S_TRIG;
      S_TRIG:      if (w_tick && (r_us_cnt == US_W'(TRIG_US - 1))) w_next = S_WAIT_RISE;
      S_WAIT_RISE: begin
        if (w_rise) w_next = S_MEASURE;
        else if (w_tick && (r_us_cnt == US_W'(TIMEOUT_US - 1))) w_next = S_FAIL;
      end
      S_MEASURE: begin
        if (w_fall) w_next = S_DONE;
        else if (w_tick && (r_us_cnt == US_W'(TIMEOUT_US - 1))) w_next = S_FAIL;
      end
      S_DONE:      w_next = S_GAP;
      S_FAIL:      w_next = S_GAP;
      S_GAP: begin
        if (CONTINUOUS == 0) w_next = S_IDLE;
        else if (w_per_next >= PER_W'(PERIOD_US)) w_next = S_TRIG;
      end
      default:     w_next = S_IDLE;
    endcase
  end

  // Microsecond prescaler, per-state us counter and trigger-to-trigger period counter
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      r_pre     <= '0;
      r_us_cnt  <= '0;
      r_per_cnt <= '0;
    end else begin
      if (w_enter_trig || w_tick) r_pre <= '0;
      else                        r_pre <= r_pre + 1'b1;

      if (w_next != r_state) r_us_cnt <= '0;
      else if (w_tick)       r_us_cnt <= r_us_cnt + 1'b1;

      if (w_enter_trig)                      r_per_cnt <= '0;
      else if ((r_state != S_IDLE) && w_tick) r_per_cnt <= r_per_cnt + 1'b1;
    end
  end

  // Centimetre conversion; the tick of the falling-edge cycle is still counted
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      r_cm_div <= '0;
      r_cm_cnt <= '0;
    end else if ((r_state == S_WAIT_RISE) && w_rise) begin
      r_cm_div <= '0;
      r_cm_cnt <= '0;
    end else if ((r_state == S_MEASURE) && w_tick) begin
      if (r_cm_div == CMD_W'(US_PER_CM - 1)) begin
        r_cm_div <= '0;
        if (r_cm_cnt != '1) r_cm_cnt <= r_cm_cnt + 1'b1;
      end else begin
        r_cm_div <= r_cm_div + 1'b1;
      end
    end
  end

  // Circular sample buffer and running sum; the first sample primes every slot
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      for (int unsigned i = 0; i < BUF_N; i++) r_buf[i] <= '0;
      r_wptr  <= '0;
      r_empty <= 1'b1;
      r_sum   <= '0;
    end else if (r_state == S_DONE) begin
      if (r_empty) begin
        for (int unsigned i = 0; i < BUF_N; i++) r_buf[i] <= r_cm_cnt;
        r_sum   <= SUM_W'(r_cm_cnt) << AVG_LOG2;
        r_empty <= 1'b0;
      end else begin
        r_buf[r_wptr] <= r_cm_cnt;
        r_sum         <= r_sum + SUM_W'(r_cm_cnt) - SUM_W'(r_buf[r_wptr]);
        r_wptr        <= (r_wptr == PTR_W'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
      end
    end
  end

  // Registered outputs: trigger, averaged distance with its strobe, timeout strobe
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      r_trigger <= 1'b0;
      r_upd     <= 1'b0;
      r_valid   <= 1'b0;
      r_terr    <= 1'b0;
      r_dist    <= '0;
    end else begin
      r_trigger <= (w_next == S_TRIG);
      r_upd     <= (r_state == S_DONE);
      r_valid   <= r_upd;
      r_terr    <= (r_state == S_FAIL);
      if (r_upd) r_dist <= DIST_W'(r_sum >> AVG_LOG2);
    end
  end

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Bench for ultrasonic_ranger: three instances at a 1 MHz clock (single-shot
// averaging, narrow single-shot without averaging, continuous) with a queue
// scoreboard of expected distances per instance.
`timescale 1ns/1ps
module tb_ultrasonic_ranger;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b, rst_c;
  logic       echo_a, echo_b, echo_c;
  logic       start_a, start_b, start_c;
  logic       trig_a, trig_b, trig_c;
  logic [8:0] dist_a, dist_c;
  logic [5:0] dist_b;
  logic       dv_a, dv_b, dv_c;
  logic       terr_a, terr_b, terr_c;
  logic       busy_a, busy_b, busy_c;

  int n_checks = 0;
  int n_errors = 0;

  logic [8:0] q_a[$];
  logic [5:0] q_b[$];
  logic [8:0] q_c[$];

  ultrasonic_ranger #(
    .CLK_HZ(1_000_000), .TRIG_US(10), .PERIOD_MS(60), .TIMEOUT_US(25000),
    .US_PER_CM(58), .AVG_LOG2(2), .DIST_W(9), .CONTINUOUS(0)
  ) u_a (
    .clk(clk), .reset_p(rst_a), .echo(echo_a), .start(start_a), .trigger(trig_a),
    .distance_cm(dist_a), .dist_valid(dv_a), .timeout_err(terr_a), .busy(busy_a)
  );

  ultrasonic_ranger #(
    .CLK_HZ(1_000_000), .TRIG_US(10), .PERIOD_MS(60), .TIMEOUT_US(25000),
    .US_PER_CM(58), .AVG_LOG2(0), .DIST_W(6), .CONTINUOUS(0)
  ) u_b (
    .clk(clk), .reset_p(rst_b), .echo(echo_b), .start(start_b), .trigger(trig_b),
    .distance_cm(dist_b), .dist_valid(dv_b), .timeout_err(terr_b), .busy(busy_b)
  );

  ultrasonic_ranger #(
    .CLK_HZ(1_000_000), .TRIG_US(10), .PERIOD_MS(5), .TIMEOUT_US(25000),
    .US_PER_CM(58), .AVG_LOG2(2), .DIST_W(9), .CONTINUOUS(1)
  ) u_c (
    .clk(clk), .reset_p(rst_c), .echo(echo_c), .start(start_c), .trigger(trig_c),
    .distance_cm(dist_c), .dist_valid(dv_c), .timeout_err(terr_c), .busy(busy_c)
  );

  // Scoreboard monitors: pop the expected distance on every dist_valid
  logic [8:0] m_exp_a, m_exp_c;
  logic [5:0] m_exp_b;
  logic       m_dv_a_d = 1'b0, m_dv_b_d = 1'b0, m_dv_c_d = 1'b0;

  always @(posedge clk) begin
    #1;
    if (dv_a) begin
      n_checks++;
      if (q_a.size() == 0) begin
        n_errors++;
        $display("FAIL sb_a_unexpected: dist_valid with nothing pending, distance_cm=%0d", dist_a);
      end else begin
        m_exp_a = q_a.pop_front();
        if (dist_a !== m_exp_a) begin
          n_errors++;
          $display("FAIL sb_a_dist: got %0d expected %0d", dist_a, m_exp_a);
        end
      end
    end
    if (dv_b) begin
      n_checks++;
      if (q_b.size() == 0) begin
        n_errors++;
        $display("FAIL sb_b_unexpected: dist_valid with nothing pending, distance_cm=%0d", dist_b);
      end else begin
        m_exp_b = q_b.pop_front();
        if (dist_b !== m_exp_b) begin
          n_errors++;
          $display("FAIL sb_b_dist: got %0d expected %0d", dist_b, m_exp_b);
        end
      end
    end
    if (dv_c) begin
      n_checks++;
      if (q_c.size() == 0) begin
        n_errors++;
        $display("FAIL sb_c_unexpected: dist_valid with nothing pending, distance_cm=%0d", dist_c);
      end else begin
        m_exp_c = q_c.pop_front();
        if (dist_c !== m_exp_c) begin
          n_errors++;
          $display("FAIL sb_c_dist: got %0d expected %0d", dist_c, m_exp_c);
        end
      end
    end
    if ((dv_a && (terr_a || m_dv_a_d)) || (dv_b && (terr_b || m_dv_b_d)) || (dv_c && (terr_c || m_dv_c_d))) begin
      n_errors++;
      $display("FAIL strobe_shape: dist_valid overlapped timeout_err or lasted 2 cycles (a=%b b=%b c=%b)", dv_a, dv_b, dv_c);
    end
    m_dv_a_d = dv_a;
    m_dv_b_d = dv_b;
    m_dv_c_d = dv_c;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    echo_a = 1'b0; echo_b = 1'b0; echo_c = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    repeat (3) cyc();
    n_checks++;
    if ({trig_a, dist_a, dv_a, terr_a, busy_a} !== 13'd0) begin
      n_errors++;
      $display("FAIL reset_outputs: trig=%b dist=%0d dv=%b terr=%b busy=%b expected all 0",
               trig_a, dist_a, dv_a, terr_a, busy_a);
    end
    // start coincident with reset release must be ignored
    rst_a = 1'b0; rst_b = 1'b0; start_a = 1'b1;
    cyc();
    start_a = 1'b0;
    repeat (5) cyc();
    n_checks++;
    if (busy_a !== 1'b0 || trig_a !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_start_ignored: busy=%b trigger=%b expected 0 0", busy_a, trig_a);
    end
  endtask

  // Single-shot measurement on instance a; poke pulses start mid-echo
  task automatic run_meas_a(input int delay, input int len, input logic [8:0] exp_cm,
                            input bit poke, input string tag);
    int k;
    int wid;
    start_a = 1'b1;
    cyc();
    start_a = 1'b0;
    k = 0;
    while (!trig_a && k < 20) begin cyc(); k++; end
    wid = 0;
    while (trig_a && wid < 100) begin cyc(); wid++; end
    n_checks++;
    if (wid != 10) begin
      n_errors++;
      $display("FAIL %s_trig_width: got %0d cycles expected 10", tag, wid);
    end
    repeat (delay) cyc();
    q_a.push_back(exp_cm);
    echo_a = 1'b1;
    for (int i = 0; i < len; i++) begin
      start_a = poke && (i == len / 2);
      cyc();
    end
    start_a = 1'b0;
    echo_a = 1'b0;
    k = 0;
    while (!dv_a && k < 20) begin cyc(); k++; end
    n_checks++;
    if (k != 5) begin
      n_errors++;
      $display("FAIL %s_latency: dist_valid after %0d cycles expected 5", tag, k);
    end
    cyc();
    n_checks++;
    if (dv_a !== 1'b0 || dist_a !== exp_cm) begin
      n_errors++;
      $display("FAIL %s_hold: dv=%b dist=%0d expected dv=0 dist=%0d", tag, dv_a, dist_a, exp_cm);
    end
  endtask

  task automatic test_single_shot();
    run_meas_a(100, 580, 9'd10, 1'b0, "t1");
    repeat (2) cyc();
    n_checks++;
    if (busy_a !== 1'b0) begin
      n_errors++;
      $display("FAIL t1_idle: busy=%b expected 0", busy_a);
    end
  endtask

  task automatic test_back_to_back();
    int trig_seen;
    run_meas_a(100, 1160, 9'd12, 1'b1, "t2a");
    trig_seen = 0;
    for (int i = 0; i < 50; i++) begin
      cyc();
      if (trig_a || busy_a) trig_seen++;
    end
    n_checks++;
    if (trig_seen != 0) begin
      n_errors++;
      $display("FAIL t2_start_dropped: %0d busy/trigger cycles after idle expected 0", trig_seen);
    end
    run_meas_a(100, 1160, 9'd15, 1'b0, "t2b");
  endtask

  task automatic test_timeout();
    int k;
    int wid;
    int dv_seen;
    start_a = 1'b1;
    cyc();
    start_a = 1'b0;
    k = 0;
    while (!trig_a && k < 20) begin cyc(); k++; end
    wid = 0;
    while (trig_a && wid < 100) begin cyc(); wid++; end
    k = 0;
    dv_seen = 0;
    while (!terr_a && k < 26000) begin
      cyc();
      k++;
      if (dv_a) dv_seen++;
    end
    n_checks++;
    if (k < 25000 || k > 25002) begin
      n_errors++;
      $display("FAIL t3_timeout_time: timeout_err after %0d cycles expected 25000..25002", k);
    end
    n_checks++;
    if (dv_seen != 0 || dist_a !== 9'd15) begin
      n_errors++;
      $display("FAIL t3_hold: dv pulses=%0d dist=%0d expected 0 and 15", dv_seen, dist_a);
    end
    cyc();
    n_checks++;
    if (terr_a !== 1'b0) begin
      n_errors++;
      $display("FAIL t3_pulse_width: timeout_err=%b on 2nd cycle expected 0", terr_a);
    end
  endtask

  task automatic test_saturate();
    int k;
    start_b = 1'b1;
    cyc();
    start_b = 1'b0;
    k = 0;
    while (!trig_b && k < 20) begin cyc(); k++; end
    k = 0;
    while (trig_b && k < 100) begin cyc(); k++; end
    repeat (20) cyc();
    q_b.push_back(6'd63);
    echo_b = 1'b1;
    repeat (5800) cyc();
    echo_b = 1'b0;
    k = 0;
    while (!dv_b && k < 20) begin cyc(); k++; end
    n_checks++;
    if (k != 5 || dist_b !== 6'd63) begin
      n_errors++;
      $display("FAIL t4_saturate: latency=%0d dist=%0d expected 5 and 63", k, dist_b);
    end
  endtask

  task automatic test_continuous();
    int  last_rise;
    int  n_rise;
    int  dv_cnt;
    int  on_at;
    int  off_at;
    logic prev_trig;
    prev_trig = 1'b0; n_rise = 0; dv_cnt = 0; last_rise = 0; on_at = -1; off_at = -1;
    rst_c = 1'b0;
    for (int t = 0; t < 17000; t++) begin
      start_c = 1'($urandom_range(0, 1));
      echo_c = (on_at >= 0) && (t >= on_at) && (t < off_at);
      cyc();
      if (dv_c) dv_cnt++;
      if (trig_c && !prev_trig) begin
        if (n_rise > 0) begin
          n_checks++;
          if (t - last_rise != 5000) begin
            n_errors++;
            $display("FAIL t5_period: trigger rises %0d cycles apart expected 5000", t - last_rise);
          end
          n_checks++;
          if (dv_cnt != 1) begin
            n_errors++;
            $display("FAIL t5_dv_per_period: %0d dist_valid pulses expected 1", dv_cnt);
          end
        end
        n_rise++;
        last_rise = t;
        dv_cnt = 0;
      end
      if (!trig_c && prev_trig) begin
        on_at = t + 50;
        off_at = t + 50 + 580;
        q_c.push_back(9'd10);
      end
      prev_trig = trig_c;
    end
    n_checks++;
    if (n_rise != 4) begin
      n_errors++;
      $display("FAIL t5_rise_count: got %0d trigger rises expected 4", n_rise);
    end
    rst_c = 1'b1;
    echo_c = 1'b0;
    start_c = 1'b0;
  endtask

  task automatic test_reset_abort();
    int k;
    int bad;
    start_a = 1'b1;
    cyc();
    start_a = 1'b0;
    k = 0;
    while (!trig_a && k < 20) begin cyc(); k++; end
    k = 0;
    while (trig_a && k < 100) begin cyc(); k++; end
    repeat (100) cyc();
    echo_a = 1'b1;
    repeat (300) cyc();
    #2;
    rst_a = 1'b1;
    #1;
    n_checks++;
    if ({trig_a, dist_a, dv_a, terr_a, busy_a} !== 13'd0) begin
      n_errors++;
      $display("FAIL t6_async_reset: trig=%b dist=%0d dv=%b terr=%b busy=%b expected all 0",
               trig_a, dist_a, dv_a, terr_a, busy_a);
    end
    echo_a = 1'b0;
    repeat (3) cyc();
    rst_a = 1'b0;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      cyc();
      if (dv_a || terr_a || busy_a || trig_a) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_errors++;
      $display("FAIL t6_after_release: %0d active cycles expected 0", bad);
    end
    n_checks++;
    if (q_a.size() != 0 || q_b.size() != 0 || q_c.size() != 0) begin
      n_errors++;
      $display("FAIL sb_drained: pending a=%0d b=%0d c=%0d expected 0 0 0",
               q_a.size(), q_b.size(), q_c.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_shot();
    test_back_to_back();
    test_timeout();
    test_saturate();
    test_continuous();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
